// File: rtl/spi_sclk_gen.sv
// Programmable SPI serial-clock generator: runtime half-period divider, all four CPOL/CPHA
// modes, bursts of num_bits SCLK cycles with one-cycle sample/shift strobes.
module spi_sclk_gen #(
   parameter int unsigned DIV_W = 8,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk_100mhz,
   input  logic             rst,
   input  logic [DIV_W-1:0] half_period,
   input  logic [CNT_W-1:0] num_bits,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             start,
   input  logic             abort,
   output logic             sclk,
   output logic             busy,
   output logic             sample_stb,
   output logic             shift_stb,
   output logic             done
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q;
   logic [DIV_W-1:0] hp_q;
   logic [CNT_W-1:0] n_q;
   logic             cpol_q;
   logic             cpha_q;
   logic [DIV_W-1:0] div_cnt_q;
   logic [CNT_W:0]   edge_cnt_q;

   logic [CNT_W:0]   last_edge;
   logic [CNT_W:0]   next_edge;
   logic             div_tc;
   logic             leading;
   logic             sample_here;

   always_comb begin
      last_edge   = {n_q, 1'b0};
      next_edge   = edge_cnt_q + (CNT_W+1)'(1);
      div_tc      = (div_cnt_q == hp_q - DIV_W'(1));
      // Odd-numbered edges leave the idle level; CPHA picks which edge type samples.
      leading     = next_edge[0];
      sample_here = leading ^ cpha_q;
   end

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state_q    <= StIdle;
         hp_q       <= DIV_W'(1);
         n_q        <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         sclk       <= 1'b0;
         busy       <= 1'b0;
         sample_stb <= 1'b0;
         shift_stb  <= 1'b0;
         done       <= 1'b0;
      end else begin
         sample_stb <= 1'b0;
         shift_stb  <= 1'b0;
         done       <= 1'b0;
         case (state_q)
            StIdle: begin
               sclk <= cpol;
               if (start && (num_bits != '0)) begin
                  hp_q       <= (half_period == '0) ? DIV_W'(1) : half_period;
                  n_q        <= num_bits;
                  cpol_q     <= cpol;
                  cpha_q     <= cpha;
                  div_cnt_q  <= '0;
                  edge_cnt_q <= '0;
                  busy       <= 1'b1;
                  state_q    <= StRun;
               end
            end
            StRun: begin
               if (abort) begin
                  state_q <= StIdle;
                  sclk    <= cpol_q;
                  busy    <= 1'b0;
               end else if (edge_cnt_q == last_edge) begin
                  state_q <= StIdle;
                  sclk    <= cpol_q;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (div_tc) begin
                  div_cnt_q  <= '0;
                  edge_cnt_q <= next_edge;
                  sclk       <= leading ? ~cpol_q : cpol_q;
                  sample_stb <= sample_here;
                  shift_stb  <= ~sample_here;
               end else begin
                  div_cnt_q <= div_cnt_q + DIV_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: per-cycle comparison against a closed-form timing model
// (edge k at T+1+k*hp, done at T+2+2N*hp) with randomized modes, divisors and ignored inputs.
module tb_spi_sclk_gen;

   logic       clk_100mhz = 1'b0;
   logic       rst;
   logic [7:0] half_period;
   logic [4:0] num_bits;
   logic       cpol;
   logic       cpha;
   logic       start;
   logic       abort;
   logic       sclk;
   logic       busy;
   logic       sample_stb;
   logic       shift_stb;
   logic       done;

   int checks = 0;
   int errors = 0;

   spi_sclk_gen #(
      .DIV_W(8),
      .CNT_W(5)
   ) dut (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .half_period(half_period),
      .num_bits   (num_bits),
      .cpol       (cpol),
      .cpha       (cpha),
      .start      (start),
      .abort      (abort),
      .sclk       (sclk),
      .busy       (busy),
      .sample_stb (sample_stb),
      .shift_stb  (shift_stb),
      .done       (done)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk_100mhz);
      #1;
   endtask

   // Drives one transfer starting in the current cycle T and compares every cycle against the
   // model. Returns in the done cycle (normal) or after the post-abort quiet window.
   task automatic run_xfer(input int hp_in, input int n, input bit pol, input bit pha,
                           input int abort_t, input bit scramble, input string name,
                           output int done_t, output int first_edge_t, output int busy_cycles);
      int hp, last_t, e, nsamp, nshift;
      bit stop, stb, lead;
      logic [4:0] exp_v, got_v;
      hp = (hp_in == 0) ? 1 : hp_in;
      last_t = 1 + 2 * n * hp;
      half_period = 8'(hp_in);
      num_bits = 5'(n);
      cpol = pol;
      cpha = pha;
      start = 1'b1;
      abort = 1'b0;
      done_t = 0;
      first_edge_t = 0;
      busy_cycles = 0;
      nsamp = 0;
      nshift = 0;
      stop = 1'b0;
      for (int t = 1; t <= last_t + 1 && !stop; t++) begin
         tick();
         start = 1'b0;
         abort = 1'b0;
         got_v = {sclk, busy, sample_stb, shift_stb, done};
         if (abort_t != 0 && t == abort_t + 1) begin
            exp_v = {pol, 4'b0000};
            checks++;
            if (got_v !== exp_v) begin
               errors++;
               $display("FAIL %s abort_exit t=%0d got {sclk,busy,smp,shf,done}=%b want %b",
                        name, t, got_v, exp_v);
            end
            for (int j = 0; j < 2 * hp + 4; j++) begin
               tick();
               got_v = {sclk, busy, sample_stb, shift_stb, done};
               checks++;
               if (got_v !== exp_v) begin
                  errors++;
                  $display("FAIL %s post_abort j=%0d got %b want %b", name, j, got_v, exp_v);
               end
            end
            stop = 1'b1;
         end else begin
            if (t <= last_t) begin
               e = (t - 1) / hp;
               stb = (e >= 1) && ((t - 1) % hp == 0);
               lead = e[0];
               exp_v = {pol ^ lead, 1'b1, stb && (lead ^ pha), stb && !(lead ^ pha), 1'b0};
            end else begin
               exp_v = {pol, 4'b0001};
            end
            checks++;
            if (got_v !== exp_v) begin
               errors++;
               $display("FAIL %s cycle t=%0d got {sclk,busy,smp,shf,done}=%b want %b",
                        name, t, got_v, exp_v);
            end
            if (busy === 1'b1) busy_cycles++;
            if (sample_stb === 1'b1) nsamp++;
            if (shift_stb === 1'b1) nshift++;
            if (first_edge_t == 0 && busy === 1'b1 && sclk !== pol) first_edge_t = t;
            if (done === 1'b1) done_t = t;
            if (t == abort_t) abort = 1'b1;
            if (scramble && t < last_t && (abort_t == 0 || t < abort_t)) begin
               half_period = 8'($urandom);
               num_bits = 5'($urandom);
               cpol = 1'($urandom);
               cpha = 1'($urandom);
               start = ($urandom_range(0, 5) == 0);
            end else begin
               half_period = 8'(hp_in);
               num_bits = 5'(n);
               cpol = pol;
               cpha = pha;
            end
         end
      end
      if (abort_t == 0) begin
         checks++;
         if (nsamp != n || nshift != n) begin
            errors++;
            $display("FAIL %s strobe_count got smp=%0d shf=%0d want %0d each",
                     name, nsamp, nshift, n);
         end
         checks++;
         if (busy_cycles != 2 * n * hp + 1) begin
            errors++;
            $display("FAIL %s busy_len got %0d want %0d", name, busy_cycles, 2 * n * hp + 1);
         end
      end
   endtask

   task automatic test_reset;
      logic [4:0] got_v;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         got_v = {sclk, busy, sample_stb, shift_stb, done};
         checks++;
         if (got_v !== 5'b0) begin
            errors++;
            $display("FAIL reset_init i=%0d got %b want 00000", i, got_v);
         end
      end
      rst = 1'b0;
      tick();
      // Mid-transfer reset with cpol=1 so sclk=0 is distinguishable from idle.
      half_period = 8'd3;
      num_bits = 5'd10;
      cpol = 1'b1;
      cpha = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_busy got %b want 1", busy);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         got_v = {sclk, busy, sample_stb, shift_stb, done};
         checks++;
         if (got_v !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid i=%0d got %b want 00000", i, got_v);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         got_v = {sclk, busy, sample_stb, shift_stb, done};
         checks++;
         if (got_v !== 5'b10000) begin
            errors++;
            $display("FAIL reset_after i=%0d got %b want 10000", i, got_v);
         end
      end
   endtask

   task automatic test_mode0;
      int d, f, b;
      run_xfer(10, 8, 1'b0, 1'b0, 0, 1'b0, "mode0", d, f, b);
      checks++;
      if (d != 162 || f != 11 || b != 161) begin
         errors++;
         $display("FAIL mode0_timing got done=%0d first=%0d busy=%0d want 162 11 161", d, f, b);
      end
      tick();
   endtask

   task automatic test_mode3;
      int d, f, b;
      run_xfer(1, 1, 1'b1, 1'b1, 0, 1'b0, "mode3", d, f, b);
      checks++;
      if (d != 4 || f != 2) begin
         errors++;
         $display("FAIL mode3_timing got done=%0d first=%0d want 4 2", d, f);
      end
      tick();
   endtask

   task automatic test_hp_zero;
      int d, f, b, n;
      n = $urandom_range(1, 31);
      run_xfer(0, n, 1'($urandom), 1'($urandom), 0, 1'b0, "hp_zero", d, f, b);
      checks++;
      if (d != 2 + 2 * n) begin
         errors++;
         $display("FAIL hp_zero_done got %0d want %0d", d, 2 + 2 * n);
      end
      tick();
   endtask

   task automatic test_num_bits_zero;
      logic [4:0] got_v;
      half_period = 8'd2;
      num_bits = 5'd0;
      cpol = 1'b1;
      cpha = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         got_v = {sclk, busy, sample_stb, shift_stb, done};
         checks++;
         if (got_v !== 5'b10000) begin
            errors++;
            $display("FAIL nbits_zero i=%0d got %b want 10000", i, got_v);
         end
         tick();
      end
   endtask

   task automatic test_long;
      int d, f, b;
      run_xfer(255, 31, 1'($urandom), 1'($urandom), 0, 1'b0, "long", d, f, b);
      checks++;
      if (d != 2 + 62 * 255) begin
         errors++;
         $display("FAIL long_done got %0d want %0d", d, 2 + 62 * 255);
      end
      tick();
   endtask

   task automatic test_abort;
      int d, f, b;
      run_xfer(4, 8, 1'b0, 1'b1, 1 + 3 * 4, 1'b0, "abort_mode1", d, f, b);
      checks++;
      if (d != 0) begin
         errors++;
         $display("FAIL abort_done got done at %0d want none", d);
      end
      // Abort coinciding with the final edge cycle must suppress done.
      run_xfer(2, 3, 1'b1, 1'b0, 1 + 2 * 3 * 2, 1'b0, "abort_terminal", d, f, b);
      checks++;
      if (d != 0) begin
         errors++;
         $display("FAIL abort_terminal_done got done at %0d want none", d);
      end
      tick();
   endtask

   task automatic test_ignored_inputs;
      int d, f, b;
      run_xfer(5, 6, 1'b0, 1'($urandom), 0, 1'b1, "ignored_inputs", d, f, b);
      checks++;
      if (d != 2 + 2 * 6 * 5) begin
         errors++;
         $display("FAIL ignored_done got %0d want %0d", d, 2 + 60);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      int d, f, b, hp2, n2;
      run_xfer(3, 2, 1'b0, 1'b0, 0, 1'b0, "b2b_first", d, f, b);
      hp2 = $urandom_range(1, 6);
      n2 = $urandom_range(1, 9);
      // Started in the done cycle of the first transfer.
      run_xfer(hp2, n2, 1'($urandom), 1'($urandom), 0, 1'b0, "b2b_second", d, f, b);
      checks++;
      if (d != 2 + 2 * n2 * hp2) begin
         errors++;
         $display("FAIL b2b_done got %0d want %0d", d, 2 + 2 * n2 * hp2);
      end
      tick();
   endtask

   task automatic test_random;
      int d, f, b;
      for (int i = 0; i < 8; i++) begin
         run_xfer($urandom_range(0, 12), $urandom_range(1, 31), 1'($urandom), 1'($urandom),
                  0, 1'($urandom), "random", d, f, b);
         repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      half_period = 8'd0;
      num_bits = 5'd0;
      cpol = 1'b0;
      cpha = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      test_reset();
      test_mode0();
      test_mode3();
      test_hp_zero();
      test_num_bits_zero();
      test_abort();
      test_ignored_inputs();
      test_back_to_back();
      test_random();
      test_long();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
